// File: rtl/mem_resp.sv
// Main-memory responder for the L1 miss path: optional write-back commit, then a fixed-latency line read.
// Optional snoop abort is compiled in when MEM_RESP_ABORT_EN is defined.
module mem_resp #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 5,
  parameter int LAT    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] endr_in,
  input  logic              wb_in,
  input  logic [ADDR_W-1:0] endr_wb_in,
  input  logic [DATA_W-1:0] dado_wb_in,
  input  logic              abt,
  output logic [DATA_W-1:0] dado_out,
  output logic              pronto,
  output logic              ocupado
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WB, READ} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] endr;
  logic [ADDR_W-1:0] endr_wb;
  logic              wb;
  logic [DATA_W-1:0] dado_wb;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              abort;

`ifdef MEM_RESP_ABORT_EN
  assign abort = abt;
`else
  logic abt_unused;
  assign abt_unused = abt;
  assign abort      = 1'b0;
`endif

  // Request fields are captured once at acceptance so the L1 may change them while we are busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      endr     <= '0;
      endr_wb  <= '0;
      wb       <= 1'b0;
      dado_wb  <= '0;
      dado_out <= '0;
      pronto   <= 1'b0;
      ocupado  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pronto <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            endr    <= endr_in;
            wb      <= wb_in;
            endr_wb <= endr_wb_in;
            dado_wb <= dado_wb_in;
            ocupado <= 1'b1;
            if (wb_in) begin
              state <= WB;
            end else begin
              state <= READ;
              cnt   <= CNT_INIT;
            end
          end
        end
        WB: begin
          if (wb) mem[endr_wb] <= dado_wb;
          state <= READ;
          cnt   <= CNT_INIT;
        end
        READ: begin
          // Abort wins over a completion landing on the same edge.
          if (abort) begin
            state   <= IDLE;
            ocupado <= 1'b0;
          end else if (cnt == 4'd0) begin
            dado_out <= mem[endr];
            pronto   <= 1'b1;
            state    <= IDLE;
            ocupado  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Directed self-checking bench for mem_resp: LAT=3 main instance plus LAT=1 and LAT=15 sweep instances.
// Abort expectations follow MEM_RESP_ABORT_EN.
module tb_mem_resp;

  logic       clock;
  logic       reset;
  logic [2:0] req_v;
  logic [4:0] endr_in;
  logic       wb_in;
  logic [4:0] endr_wb_in;
  logic [9:0] dado_wb_in;
  logic       abt;

  logic [9:0] dado3, dado1, dado15;
  logic       pronto3, pronto1, pronto15;
  logic       ocup3, ocup1, ocup15;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int sel = 0;
  int n3 = 0, n1 = 0, n15 = 0;

  logic [9:0] dado_s;
  logic       pronto_s, ocup_s;

  mem_resp #(.DATA_W(10), .ADDR_W(5), .LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req(req_v[0]), .endr_in(endr_in), .wb_in(wb_in),
    .endr_wb_in(endr_wb_in), .dado_wb_in(dado_wb_in), .abt(abt),
    .dado_out(dado3), .pronto(pronto3), .ocupado(ocup3));

  mem_resp #(.DATA_W(10), .ADDR_W(5), .LAT(1)) dut1 (
    .clock(clock), .reset(reset), .req(req_v[1]), .endr_in(endr_in), .wb_in(wb_in),
    .endr_wb_in(endr_wb_in), .dado_wb_in(dado_wb_in), .abt(abt),
    .dado_out(dado1), .pronto(pronto1), .ocupado(ocup1));

  mem_resp #(.DATA_W(10), .ADDR_W(5), .LAT(15)) dut15 (
    .clock(clock), .reset(reset), .req(req_v[2]), .endr_in(endr_in), .wb_in(wb_in),
    .endr_wb_in(endr_wb_in), .dado_wb_in(dado_wb_in), .abt(abt),
    .dado_out(dado15), .pronto(pronto15), .ocupado(ocup15));

  always_comb begin
    dado_s   = dado3;
    pronto_s = pronto3;
    ocup_s   = ocup3;
    if (sel == 1) begin
      dado_s = dado1; pronto_s = pronto1; ocup_s = ocup1;
    end else if (sel == 2) begin
      dado_s = dado15; pronto_s = pronto15; ocup_s = ocup15;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Count every sampled pronto-high cycle so extra or stretched pulses show up in the totals.
  always @(negedge clock) begin
    if (pronto3)  n3  <= n3 + 1;
    if (pronto1)  n1  <= n1 + 1;
    if (pronto15) n15 <= n15 + 1;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where pronto is seen, with req already dropped.
  task automatic applyStimulus(input int s, input logic [4:0] addr, input logic wb,
                               input logic [4:0] wba, input logic [9:0] wbd,
                               output int lat, output logic [9:0] data, output int pcyc);
    sel        = s;
    endr_in    = addr;
    wb_in      = wb;
    endr_wb_in = wba;
    dado_wb_in = wbd;
    req_v[s]   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("ocupado_after_accept", int'(ocup_s), 1);
    endr_in    = addr ^ 5'h1F;
    endr_wb_in = wba ^ 5'h1F;
    dado_wb_in = ~wbd;
    lat  = -1;
    data = '0;
    pcyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (pronto_s) begin
        lat  = k;
        data = dado_s;
        pcyc = cycle;
        break;
      end
    end
    checkOutput("ocupado_at_pronto", int'(ocup_s), 0);
    req_v[s] = 1'b0;
    wb_in    = 1'b0;
  endtask

  int         lat, c1, c2, first;
  logic [9:0] d, hold;

  initial begin
    reset      = 1'b1;
    req_v      = '0;
    endr_in    = '0;
    wb_in      = 1'b0;
    endr_wb_in = '0;
    dado_wb_in = '0;
    abt        = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset_pronto", int'(pronto3), 0);
    checkOutput("reset_ocupado", int'(ocup3), 0);
    checkOutput("reset_dado", int'(dado3), 0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(0, 5'd4, 1'b1, 5'd9, 10'h2A5, lat, d, c1);
    checkOutput("wb_diff_lat", lat, 4);
    checkOutput("wb_diff_data", int'(d), 0);
    @(negedge clock);
    applyStimulus(0, 5'd9, 1'b0, 5'd0, 10'h000, lat, d, c1);
    checkOutput("read_wb_addr_lat", lat, 3);
    checkOutput("read_wb_addr_data", int'(d), 'h2A5);
    @(negedge clock);
    applyStimulus(0, 5'd12, 1'b1, 5'd12, 10'h155, lat, d, c1);
    checkOutput("wb_same_lat", lat, 4);
    checkOutput("wb_same_data", int'(d), 'h155);
    @(negedge clock);

    applyStimulus(0, 5'd12, 1'b0, 5'd0, 10'h000, lat, d, c1);
    checkOutput("b2b_first_data", int'(d), 'h155);
    applyStimulus(0, 5'd9, 1'b0, 5'd0, 10'h000, lat, d, c2);
    checkOutput("b2b_second_data", int'(d), 'h2A5);
    checkOutput("b2b_spacing", c2 - c1, 4);
    @(negedge clock);
    checkOutput("b2b_single_pulse", int'(pronto3), 0);

    // Abort: request addr 4 (holds 0) while dado_out shows 0x2A5; abt sampled at t+2.
    hold       = dado3;
    sel        = 0;
    endr_in    = 5'd4;
    req_v[0]   = 1'b1;
    @(posedge clock);
    first = -1;
    @(posedge clock);
    @(negedge clock);
    abt      = 1'b1;
    req_v[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    abt = 1'b0;
`ifdef MEM_RESP_ABORT_EN
    checkOutput("abort_ocupado", int'(ocup3), 0);
`else
    checkOutput("abort_ocupado", int'(ocup3), 1);
`endif
    for (int k = 3; k <= 8; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (pronto3 && first < 0) first = k;
    end
`ifdef MEM_RESP_ABORT_EN
    checkOutput("abort_no_pronto", first, -1);
    checkOutput("abort_dado_held", int'(dado3), int'(hold));
`else
    checkOutput("noabort_pronto", first, 3);
    checkOutput("noabort_dado", int'(dado3), 0);
`endif

    // Reset mid-READ after a write-back to addr 5 has committed.
    endr_in    = 5'd5;
    wb_in      = 1'b1;
    endr_wb_in = 5'd5;
    dado_wb_in = 10'h3FF;
    req_v[0]   = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_pronto", int'(pronto3), 0);
    checkOutput("midreset_ocupado", int'(ocup3), 0);
    checkOutput("midreset_dado", int'(dado3), 0);
    req_v[0] = 1'b0;
    wb_in    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(0, 5'd5, 1'b0, 5'd0, 10'h000, lat, d, c1);
    checkOutput("after_reset_lat", lat, 3);
    checkOutput("after_reset_data", int'(d), 0);
    @(negedge clock);

    applyStimulus(1, 5'd3, 1'b1, 5'd3, 10'h0AB, lat, d, c1);
    checkOutput("lat1_wb_lat", lat, 2);
    checkOutput("lat1_wb_data", int'(d), 'h0AB);
    @(negedge clock);
    applyStimulus(1, 5'd3, 1'b0, 5'd0, 10'h000, lat, d, c1);
    checkOutput("lat1_lat", lat, 1);
    checkOutput("lat1_data", int'(d), 'h0AB);
    @(negedge clock);
    applyStimulus(2, 5'd7, 1'b0, 5'd0, 10'h000, lat, d, c1);
    checkOutput("lat15_lat", lat, 15);
    checkOutput("lat15_data", int'(d), 0);
    repeat (3) @(negedge clock);

`ifdef MEM_RESP_ABORT_EN
    checkOutput("pulses_lat3", n3, 6);
`else
    checkOutput("pulses_lat3", n3, 7);
`endif
    checkOutput("pulses_lat1", n1, 2);
    checkOutput("pulses_lat15", n15, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
